uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter that consumes the one-cycle bit-period enable produced by the team's clock-enable generator. It accepts parallel words over a valid/ready handshake and shifts each one out LSB-first as an asynchronous serial frame: start bit, data, optional parity, stop bit(s). All bit boundaries align to enable pulses. It sits between the SoC-side producer (debug/console path) and the board TX pin.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- cke  input  1  bit-period enable; one-cycle pulse every T clk cycles, T ≥ 2
- data  input  DATA_W  word to transmit; sampled on handshake
- valid  input  1  producer has a word
- ready  output  1  block can accept a word
- tx  output  1  serial line; idle high
- busy  output  1  frame in progress

## Operation
- States: IDLE, SYNC, START, DATA, PARITY (only with macro), STOP.
- IDLE: ready=1, tx=1, busy=0. valid&&ready at a clk edge latches data into the shift register and moves to SYNC. A cke in the same cycle is ignored.
- SYNC: tx=1, ready=0, busy=1. Waits for the next cke, so the start bit has a full period.
- On each cke, state advances:
  - SYNC → START: tx=0.
  - START → DATA: tx=sh[0], bit counter=0.
  - DATA: shift right, increment counter. After bit DATA_W-1, go to PARITY if enabled, otherwise to STOP.
  - PARITY → STOP: tx=1.
  - STOP: tx=1. Lasts STOP_BITS cke periods, counted by the stop counter. The cke that ends the last stop bit returns to IDLE.
- tx is a registered output. It changes only in the cycle of the state transition that selects the new bit.
- Parity: even parity, computed as the XOR of the latched word at accept time.
- ready = (state==IDLE) && !rst. It is combinational from state, with no dependency on valid.
- valid while not ready: ignored. data is never re-sampled mid-frame.
- Reset, including mid-frame: state=IDLE, tx=1, busy=0, counters=0, shift register=0. The partial frame is abandoned with no glitch low.

## Timing
- Handshake to first tx low: the first cke strictly after the accept edge, plus one cycle. This is at most T+1 cycles.
- Every bit, start through stop, holds for exactly T clk cycles.
- Frame length in cke pulses: 1 (sync) + 1 + DATA_W + P + STOP_BITS, where P=1 with parity and 0 without.
- ready rises in the cycle after the cke that ends the last stop bit. A back-to-back accept in that same cycle produces a contiguous next frame after SYNC.
- Accept and cke coincident: the accept wins, and that cke is not counted.
- cke held high continuously: each cycle counts as one bit period (degenerate T=1). This case is not required to be tested.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state present. One even-parity bit is sent between the last data bit and the stop bit(s).
- Undefined: no parity logic or state. DATA goes directly to STOP.

## Structure
- Shared package uart_pkg holds:
  - state enum uart_tx_state_t (IDLE, SYNC, START, DATA, PARITY, STOP)
  - constant for the idle line level (1'b1)
  - function even_parity
- The bit counter is sized $clog2(DATA_W); the stop counter is 1 bit.
- No sub-module. The shift register, counters and FSM are inline. The bit-period enable is instantiated by the parent, not inside this block.

## Test plan
- DATA_W=8, T=4, no parity: send 0x55 → tx reads start 0, then 1,0,1,0,1,0,1,0, then stop 1. Each bit is 4 cycles. ready returns after 11 cke pulses from accept.
- Parity enabled, send 0x07 → parity bit 1 after the data bits. Send 0x03 → parity bit 0.
- STOP_BITS=2, send 0xFF → tx high for 8 cycles after the last data bit before ready rises.
- Two words 0xA5 and 0x3C with valid held high continuously → the second is accepted in the cycle ready rises. Frames are back-to-back, with only the SYNC period (idle 1) between them.
- Assert valid in the same cycle as cke in IDLE → the start bit begins at the following cke, not the coincident one.
- Assert rst during data bit 3 of 0x00 → tx=1 and ready=0 immediately. After release, ready=1, and a new word 0x81 is sent cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state type, idle line level and parity helper
package uart_pkg;

   typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} uart_tx_state_t;

   localparam logic IDLE_LVL = 1'b1;

   function automatic logic even_parity(input logic [8:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: LSB-first async serial transmitter paced by an external bit-period enable; UART_TX_PARITY_EN adds an even-parity bit
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cke,
   input  logic [DATA_W-1:0] data,
   input  logic              valid,
   output logic              ready,
   output logic              tx,
   output logic              busy
);

   localparam int BW = $clog2(DATA_W);

   uart_tx_state_t    state_q;
   logic [DATA_W-1:0] sh_q;
   logic [BW-1:0]     bit_q;
   logic              stop_q;
   logic              tx_q;
   logic              busy_q;
`ifdef UART_TX_PARITY_EN
   logic              par_q;
`endif

   assign ready = (state_q == IDLE) && !rst;
   assign tx    = tx_q;
   assign busy  = busy_q;

   // frame sequencer: every state advance except the accept waits for a cke pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         tx_q    <= IDLE_LVL;
         busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (valid) begin
               state_q <= SYNC;
               sh_q    <= data;
               busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
               par_q   <= even_parity(9'(data));
`endif
            end
            SYNC: if (cke) begin
               state_q <= START;
               tx_q    <= 1'b0;
            end
            START: if (cke) begin
               state_q <= DATA;
               tx_q    <= sh_q[0];
               bit_q   <= '0;
            end
            DATA: if (cke) begin
               if (bit_q == BW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_q <= PARITY;
                  tx_q    <= par_q;
`else
                  state_q <= STOP;
                  tx_q    <= IDLE_LVL;
                  stop_q  <= 1'b0;
`endif
               end else begin
                  sh_q  <= sh_q >> 1;
                  tx_q  <= sh_q[1];
                  bit_q <= bit_q + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (cke) begin
               state_q <= STOP;
               tx_q    <= IDLE_LVL;
               stop_q  <= 1'b0;
            end
`endif
            STOP: if (cke) begin
               if (stop_q == 1'(STOP_BITS - 1)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  stop_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks uart_tx (1 and 2 stop bits) against a bit-list reference model, table vectors and corner sequences
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int T = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cke = 1'b0;
   logic [7:0] data = 8'h00;
   logic [1:0] valid = 2'b00;
   logic [1:0] rdy, line, bsy;
   logic       rnd_cke = 1'b0;
   int         cyc = 0;
   int         tests = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   uart_tx #(.DATA_W(8), .STOP_BITS(1)) u0 (
      .clk(clk), .rst(rst), .cke(cke), .data(data), .valid(valid[0]),
      .ready(rdy[0]), .tx(line[0]), .busy(bsy[0]));

   uart_tx #(.DATA_W(8), .STOP_BITS(2)) u1 (
      .clk(clk), .rst(rst), .cke(cke), .data(data), .valid(valid[1]),
      .ready(rdy[1]), .tx(line[1]), .busy(bsy[1]));

   // reference model: a frame is the list of wire bits; ph counts cke pulses since accept (0 = sync wait)
   logic        act [2] = '{1'b0, 1'b0};
   int          ph  [2] = '{0, 0};
   int          nb  [2] = '{1, 1};
   logic [15:0] fr  [2] = '{16'hFFFF, 16'hFFFF};

   function automatic logic [15:0] frame(input logic [7:0] d);
      logic [15:0] f;
      f    = 16'hFFFF;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = d[i];
      if (P != 0) f[9] = ^d;
      return f;
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) act[k] <= 1'b0;
         else if (!act[k]) begin
            if (valid[k]) begin
               act[k] <= 1'b1;
               ph[k]  <= 0;
               fr[k]  <= frame(data);
               nb[k]  <= 9 + P + k + 1;
            end
         end else if (cke) begin
            if (ph[k] == nb[k]) act[k] <= 1'b0;
            else ph[k] <= ph[k] + 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
      end
   endtask

   task automatic check_cycle();
      for (int k = 0; k < 2; k++) begin
         logic e;
         e = (act[k] && ph[k] >= 1) ? fr[k][ph[k]-1] : 1'b1;
         chk($sformatf("tx%0d", k), 32'(line[k]), 32'(e));
         chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!act[k] && !rst));
         chk($sformatf("busy%0d", k), 32'(bsy[k]), 32'(act[k]));
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      cke = rnd_cke ? (!cke && $urandom_range(0, 2) == 0) : (cyc % T == 0);
      cyc++;
   endtask

   task automatic wait_ready(input int k);
      int n = 0;
      while (!rdy[k] && n < 400) begin step(); n++; end
      if (n >= 400) chk("wait_ready_timeout", 32'(rdy[k]), 32'd1);
   endtask

   // sends one word; counts cke pulses to ready, stop-bit high cycles and the bit after the last data bit
   task automatic send(input int k, input logic [7:0] d, input int exp_ck, input int exp_hi, input logic exp_par);
      int   n = 0;
      int   c = 0;
      int   hi = 0;
      logic got = 1'bx;
      bit   seen = 0;
      wait_ready(k);
      data = d; valid[k] = 1'b1;
      step();
      valid[k] = 1'b0;
      while (!rdy[k] && n < 400) begin
         c += int'(cke);
         step();
         n++;
         if (c == 10 && !seen) begin seen = 1; got = line[k]; end
         if (c >= 10 + P && bsy[k] && line[k]) hi++;
      end
      if (n >= 400) chk("send_timeout", 32'(rdy[k]), 32'd1);
      chk($sformatf("ckes_%0h", d), 32'(c), 32'(exp_ck));
      chk($sformatf("stop_high_%0h", d), 32'(hi), 32'(exp_hi));
      chk($sformatf("post_data_bit_%0h", d), 32'(got), 32'((P != 0) ? exp_par : 1'b1));
   endtask

   typedef struct {
      int         k;
      logic [7:0] d;
      int         ck;
      int         hi;
      logic       par;
   } vec_t;

   vec_t vt [6];

   initial begin
      int n;
      int c;
      vt[0] = '{0, 8'h55, 11 + P, 4, 1'b0};
      vt[1] = '{0, 8'h07, 11 + P, 4, 1'b1};
      vt[2] = '{0, 8'h03, 11 + P, 4, 1'b0};
      vt[3] = '{1, 8'hFF, 12 + P, 8, 1'b0};
      vt[4] = '{1, 8'h5A, 12 + P, 8, 1'b0};
      vt[5] = '{0, 8'h80, 11 + P, 4, 1'b1};

      repeat (3) step();
      chk("reset_tx", 32'(line), 32'h3);
      chk("reset_ready", 32'(rdy), 32'h0);
      rst = 1'b0;
      step();
      chk("post_reset_ready", 32'(rdy), 32'h3);
      chk("post_reset_busy", 32'(bsy), 32'h0);

      foreach (vt[i]) send(vt[i].k, vt[i].d, vt[i].ck, vt[i].hi, vt[i].par);

      // back-to-back: valid held high, second word taken the cycle ready returns
      wait_ready(0);
      data = 8'hA5; valid[0] = 1'b1;
      step();
      data = 8'h3C;
      n = 0;
      while (!rdy[0] && n < 400) begin step(); n++; end
      step();
      valid[0] = 1'b0;
      chk("b2b_ready_drop", 32'(rdy[0]), 32'd0);
      chk("b2b_busy", 32'(bsy[0]), 32'd1);
      wait_ready(0);

      // accept coincident with cke: that cke must not start the frame
      n = 0;
      do begin step(); n++; end while ((!cke || !rdy[0]) && n < 50);
      data = 8'h96; valid[0] = 1'b1;
      step();
      valid[0] = 1'b0;
      n = 1;
      while (line[0] !== 1'b0 && n < 50) begin step(); n++; end
      chk("coincident_latency", 32'(n), 32'(T + 1));
      wait_ready(0);

      // reset in the middle of data bit 3 of 0x00
      data = 8'h00; valid[0] = 1'b1;
      step();
      valid[0] = 1'b0;
      c = 0; n = 0;
      while (c < 5 && n < 100) begin c += int'(cke); step(); n++; end
      step(); step();
      chk("mid_bit3_low", 32'(line[0]), 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_tx_high", 32'(line[0]), 32'd1);
      chk("rst_ready_low", 32'(rdy[0]), 32'd0);
      chk("rst_busy_low", 32'(bsy[0]), 32'd0);
      step(); step();
      rst = 1'b0;
      step();
      chk("rst_release_ready", 32'(rdy[0]), 32'd1);
      send(0, 8'h81, 11 + P, 4, 1'b0);

      // randomized traffic with irregular cke spacing and occasional resets
      rnd_cke = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         step();
         data  = 8'($urandom);
         valid = 2'($urandom);
         rst   = ($urandom_range(0, 299) == 0);
      end
      rst = 1'b0; valid = 2'b00; rnd_cke = 1'b0;
      n = 0;
      while (rdy !== 2'b11 && n < 200) begin step(); n++; end
      chk("final_idle", 32'(rdy), 32'h3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
